// File: rtl/rr_select_pkg.sv
// Shared definitions for the four-channel round-robin select arbiter.
package rr_select_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot grant vector for a binary channel index.
    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_select_4_pick.sv
// Combinational round-robin picker: rotate the request vector so the pointer
// channel sits at bit 0, take the lowest set bit, then add the pointer back.
module rr_pick4
    import rr_select_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    logic [NUM_CH-1:0] rot;
    logic [SEL_W-1:0]  off;

    // Rotate requests so bit 0 is the highest-priority channel.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rot[i] = req[ptr + SEL_W'(i)];
        end
    end

    // Fixed-priority encode: lowest set bit of the rotated vector wins.
    always_comb begin
        off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    // Add-back wraps modulo 4 through the 2-bit width.
    assign idx = ptr + off;
    assign any = |req;

endmodule

// File: rtl/rr_select_4.sv
// Four-channel round-robin arbiter driving the select bus of an upstream 4:1
// mux. Grant, select and valid are registered and held until valid && ready.
module rr_select_4
    import rr_select_pkg::*;
#(
    parameter logic [SEL_W-1:0] PTR_RESET = 2'd0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              ready,
    output logic [SEL_W-1:0]  select,
    output logic [NUM_CH-1:0] grant,
    output logic              valid
);

    state_t            state;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  next_ptr;
    logic [SEL_W-1:0]  pick_ptr;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;

    // Pointer after serving the current channel; that channel drops to last place.
    assign next_ptr = select + SEL_W'(1);

    // In GRANT the picker is only consulted on a handshake, so it always looks
    // ahead with the post-handshake pointer; in IDLE it uses the stored one.
    assign pick_ptr = (state == GRANT) ? next_ptr : ptr;

    rr_pick4 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Arbitration FSM with registered outputs; reset drops valid immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state  <= IDLE;
            ptr    <= PTR_RESET;
            select <= '0;
            grant  <= '0;
            valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // ready is ignored here; ptr does not move without a transfer.
                    if (pick_any) begin
                        select <= pick_idx;
                        grant  <= onehot(pick_idx);
                        valid  <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    // Grant is held regardless of req until the handshake.
                    if (ready) begin
                        ptr <= next_ptr;
                        if (pick_any) begin
                            select <= pick_idx;
                            grant  <= onehot(pick_idx);
                        end else begin
                            grant <= '0;
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_select_4.sv
// Directed self-checking bench for rr_select_4 with hand-computed expectations.
module tb_rr_select_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic [1:0] select;
    logic [3:0] grant;
    logic       valid;

    int n_tests = 0;
    int n_fail  = 0;

    rr_select_4 #(.PTR_RESET(2'd0)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .ready  (ready),
        .select (select),
        .grant  (grant),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] g);
        check({tag, ".valid"},  32'(valid),  32'(v));
        check({tag, ".select"}, 32'(select), 32'(s));
        check({tag, ".grant"},  32'(grant),  32'(g));
    endtask

    initial begin
        logic [1:0] rot_seq [6];
        rot_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst   = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        expect_out("reset", 1'b0, 2'd0, 4'b0000);

        // Release reset, single request on channel C.
        step();
        rst = 1'b0;
        step();
        req = 4'b0100;
        step();
        expect_out("single", 1'b1, 2'd2, 4'b0100);

        // Hold for 5 cycles with ready low and req dropped.
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out($sformatf("hold%0d", i), 1'b1, 2'd2, 4'b0100);
        end

        // Handshake with no requests: back to idle, select keeps last value, ptr = 3.
        ready = 1'b1;
        step();
        expect_out("release", 1'b0, 2'd2, 4'b0000);

        // Wrap: ptr = 3, req = 0101 -> channel 0, then channel 2, then 0 again.
        ready = 1'b0;
        req   = 4'b0101;
        step();
        expect_out("wrap0", 1'b1, 2'd0, 4'b0001);
        ready = 1'b1;
        step();
        expect_out("wrap2", 1'b1, 2'd2, 4'b0100);
        step();
        expect_out("wrap0b", 1'b1, 2'd0, 4'b0001);

        // Drain: served channel 0 with no requests -> idle, ptr = 1.
        req = 4'b0000;
        step();
        expect_out("drain", 1'b0, 2'd0, 4'b0000);

        // Ready in idle is ignored for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("idle_ready%0d.valid", i), 32'(valid), 32'(1'b0));
        end
        req   = 4'b0010;
        ready = 1'b0;
        step();
        expect_out("chan1", 1'b1, 2'd1, 4'b0010);

        // Serve channel 1 -> ptr = 2, then idle with ready high; ptr must stay 2.
        req   = 4'b0000;
        ready = 1'b1;
        step();
        check("idle2.valid", 32'(valid), 32'(1'b0));
        for (int i = 0; i < 3; i++) begin
            step();
        end
        // From ptr 2: channel 2 absent, channel 3 wins over 0 and 1.
        req   = 4'b1011;
        ready = 1'b0;
        step();
        expect_out("ptr_hold", 1'b1, 2'd3, 4'b1000);

        // Async reset between edges while granting channel 3.
        #2 rst = 1'b1;
        #1;
        expect_out("async_rst", 1'b0, 2'd0, 4'b0000);
        step();
        rst = 1'b0;

        // Rotation from reset priority: 0,1,2,3,0,1 with no bubble.
        req   = 4'b1111;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            expect_out($sformatf("rot%0d", i), 1'b1, rot_seq[i], 4'(1) << rot_seq[i]);
        end

        // Final drain to idle.
        req = 4'b0000;
        step();
        check("end.valid", 32'(valid), 32'(1'b0));
        check("end.grant", 32'(grant), 32'(4'b0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
